// File: rtl/gray_cntr_pkg.sv
// Shared Gray-code helpers and mode constants for the Gray up/down counter.
package gray_cntr_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;
  localparam int unsigned MAX_W     = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the Gray bit XOR the next-higher binary bit.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_cntr_ch.sv
// One counter channel: Gray-coded count register, event pulse and sticky flag.
module gray_cntr_ch
  import gray_cntr_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SAT_MODE = MODE_WRAP
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             incr_i,
  input  logic             decr_i,
  input  logic             clr_i,
  input  logic             evt_clr_i,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             evt_o,
  output logic             evt_sticky_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_d;
  logic             evt_d;
  logic             sticky_d;

  assign bin_o = WIDTH'(gray2bin(MAX_W'(gray_o)));

  // Next count from the decoded current count; only the Gray value is stored.
  always_comb begin
    bin_nxt = bin_o;
    evt_d   = 1'b0;
    if (clr_i) begin
      bin_nxt = '0;
    end else if (incr_i && !decr_i) begin
      if (bin_o == CNT_MAX) begin
        evt_d = 1'b1;
        if (SAT_MODE == MODE_WRAP) bin_nxt = '0;
      end else begin
        bin_nxt = bin_o + WIDTH'(1);
      end
    end else if (decr_i && !incr_i) begin
      if (bin_o == '0) begin
        evt_d = 1'b1;
        if (SAT_MODE == MODE_WRAP) bin_nxt = CNT_MAX;
      end else begin
        bin_nxt = bin_o - WIDTH'(1);
      end
    end
    gray_d   = WIDTH'(bin2gray(MAX_W'(bin_nxt)));
    sticky_d = evt_d | (evt_sticky_o & ~evt_clr_i);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      gray_o       <= '0;
      evt_o        <= 1'b0;
      evt_sticky_o <= 1'b0;
    end else begin
      gray_o       <= gray_d;
      evt_o        <= evt_d;
      evt_sticky_o <= sticky_d;
    end
  end

endmodule

// File: rtl/gray_updn_cntr.sv
// Array of independent Gray-coded up/down counters sharing one clock and reset.
module gray_updn_cntr
  import gray_cntr_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned SAT_MODE = MODE_WRAP
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [N_CH-1:0]       incr_i,
  input  logic [N_CH-1:0]       decr_i,
  input  logic [N_CH-1:0]       clr_i,
  input  logic [N_CH-1:0]       evt_clr_i,
  output logic [N_CH*WIDTH-1:0] gray_o,
  output logic [N_CH*WIDTH-1:0] bin_o,
  output logic [N_CH-1:0]       evt_o,
  output logic [N_CH-1:0]       evt_sticky_o
);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    gray_cntr_ch #(
      .WIDTH   (WIDTH),
      .SAT_MODE(SAT_MODE)
    ) u_ch (
      .clk_i       (clk_i),
      .arst_ni     (arst_ni),
      .incr_i      (incr_i[ch]),
      .decr_i      (decr_i[ch]),
      .clr_i       (clr_i[ch]),
      .evt_clr_i   (evt_clr_i[ch]),
      .gray_o      (gray_o[ch*WIDTH +: WIDTH]),
      .bin_o       (bin_o[ch*WIDTH +: WIDTH]),
      .evt_o       (evt_o[ch]),
      .evt_sticky_o(evt_sticky_o[ch])
    );
  end

endmodule
